// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128 key schedule.
//   Emits round keys 0..10, one per key_valid/key_ready handshake.
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     start      load key_in and begin a job (honoured only in IDLE)
//     key_in     128-bit cipher key, bits [127:96] = w0
//     key_ready  consumer accepts round_key this cycle
//     round_key  current round key (registered)
//     round_idx  index of round_key, 0..10
//     key_valid  round_key/round_idx are valid
//     busy       high from start acceptance until done
//     done       one-cycle pulse after round 10 is accepted
//   Handshake: a transfer happens on a rising edge where key_valid && key_ready.
//   While key_valid is high and key_ready is low, round_key/round_idx hold.
//   key_ready is ignored while key_valid is low.
//   Also contains aes_rcon (round constant lookup) and aes_sbox (forward S-box).

module aes_rcon (
    input  logic [3:0] round,
    output logic [7:0] rcon
);
    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end
endmodule

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Entry 0 sits in the top byte, so byte n lives at [2047-8n -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;
    assign base = 11'd2047 - {a, 3'b000};
    assign y    = SBOX[base -: 8];
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;

    localparam logic [3:0] LAST = 4'(NR);

    logic [1:0]  state;
    logic [3:0]  rcon_round;
    logic [7:0]  rcon_out;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic [127:0] next_key;

    // Rcon index is round_idx+1, clamped so the lookup is never driven
    // past the last round while round 10 is waiting to be accepted.
    assign rcon_round = (round_idx < LAST) ? round_idx + 4'd1 : LAST;

    aes_rcon u_rcon (.round(rcon_round), .rcon(rcon_out));

    assign w0  = round_key[127:96];
    assign w1  = round_key[95:64];
    assign w2  = round_key[63:32];
    assign w3  = round_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

    assign t  = sub ^ {rcon_out, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= 4'd0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (key_valid && key_ready) begin
                        if (round_idx == LAST) begin
                            // Final key accepted: done is high during FIN.
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            round_key <= next_key;
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: self-checking bench for aes_key_expand.
//   Reference key schedule is built from the word recurrence
//   w[i] = w[i-4] ^ f(w[i-1]) using an S-box derived from GF(2^8) inverses.

module tb_aes_key_expand;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .key_ready(key_ready), .round_key(round_key), .round_idx(round_idx),
        .key_valid(key_valid), .busy(busy), .done(done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- reference model ----------------
    logic [7:0]   sb [0:255];
    logic [127:0] exp_q [$];
    logic [127:0] got [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_expected(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        exp_q.delete();
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endtask

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start_job(input logic [127:0] key);
        load_expected(key);
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        key_in = $urandom() ? {4{$urandom()}} : '0;  // later key_in changes must not matter
    endtask

    // mode 0: ready high; 1: random ready; 2: stall 5 cycles at round 3;
    // 3: re-assert start at round 5; 4: reset at round 6.
    task automatic drain(input int mode, input logic [127:0] alt_key);
        int hs = 0;
        int cyc = 0;
        int stall = 0;
        bit injected = 0;
        while (hs < 11 && cyc < 400) begin
            if (mode == 4 && key_valid && round_idx == 4'd6) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_round_key", round_key, '0);
                chk("rst_round_idx", {124'h0, round_idx}, '0);
                chk("rst_key_valid", {127'h0, key_valid}, '0);
                chk("rst_busy", {127'h0, busy}, '0);
                chk("rst_done", {127'h0, done}, '0);
                exp_q.delete();
                return;
            end
            chk("key_valid_hi", {127'h0, key_valid}, 128'h1);
            chk("busy_hi", {127'h0, busy}, 128'h1);
            chk("round_idx", {124'h0, round_idx}, 128'(hs));
            chk("round_key", round_key, exp_q[0]);
            key_ready = 1'b1;
            if (mode == 1) key_ready = 1'($urandom_range(0, 1));
            if (mode == 2 && round_idx == 4'd3 && stall < 5) begin
                key_ready = 1'b0;
                stall++;
                chk("stall_key", round_key, 128'h3d80477d4716fe3e1e237e446d7a883b);
            end
            if (mode == 3 && round_idx == 4'd5 && !injected) begin
                start    = 1'b1;
                key_in   = alt_key;
                injected = 1;
            end
            if (key_valid && key_ready) begin
                got[hs] = round_key;
                hs++;
                void'(exp_q.pop_front());
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        chk("handshakes", 128'(hs), 128'd11);
        if (mode == 0) chk("latency_cycles", 128'(cyc), 128'd11);
        if (mode == 2) chk("stall_cycles", 128'(stall), 128'd5);
        chk("done_pulse", {127'h0, done}, 128'h1);
        chk("busy_low_at_done", {127'h0, busy}, '0);
        chk("key_valid_low", {127'h0, key_valid}, '0);
        chk("round_idx_kept", {124'h0, round_idx}, 128'd10);
        key_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dc;
        logic [127:0] kb;
        rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
        build_sbox();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_round_key", round_key, '0);
        chk("reset_idx", {124'h0, round_idx}, '0);
        chk("reset_valid", {127'h0, key_valid}, '0);
        chk("reset_busy", {127'h0, busy}, '0);
        chk("reset_done", {127'h0, done}, '0);
        key_ready = 1'b1;           // ready with nothing valid: no effect
        repeat (2) tick();
        chk("idle_valid", {127'h0, key_valid}, '0);

        // 1: FIPS-197 vector, ready high
        start_job(FIPS_KEY);
        chk("fips_r0_latency", round_key, FIPS_KEY);
        drain(0, '0);
        chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        chk("done_one_cycle", {127'h0, done}, '0);
        chk("done_count_1", 128'(done_cnt), 128'd1);

        // 2: backpressure at round 3
        start_job(FIPS_KEY);
        drain(2, '0);
        chk("bp_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();

        // 3: all-zero key, random ready
        dc = done_cnt;
        start_job('0);
        drain(1, '0);
        chk("zero_r1", got[1], 128'h62636363626363636263636362636363);
        chk("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();
        chk("zero_done_once", 128'(done_cnt - dc), 128'd1);

        // 4: start re-asserted mid-run with a different random key
        start_job({$urandom(), $urandom(), $urandom(), $urandom()});
        drain(3, {$urandom(), $urandom(), $urandom(), $urandom()});
        tick();

        // 5: reset at round 6, then FIPS again
        dc = done_cnt;
        start_job(FIPS_KEY);
        drain(4, '0);
        repeat (3) tick();
        chk("abort_no_done", 128'(done_cnt), 128'(dc));
        start_job(FIPS_KEY);
        chk("post_rst_r0", round_key, FIPS_KEY);
        drain(0, '0);
        chk("post_rst_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("post_rst_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // 6: back-to-back; start held through the done (FIN) cycle
        kb = {$urandom(), $urandom(), $urandom(), $urandom()};
        start  = 1'b1;
        key_in = kb;
        tick();
        chk("fin_start_ignored", {127'h0, key_valid}, '0);
        chk("fin_done_cleared", {127'h0, done}, '0);
        tick();
        start = 1'b0;
        load_expected(kb);
        chk("b2b_valid", {127'h0, key_valid}, 128'h1);
        chk("b2b_r0", round_key, kb);
        drain(1, '0);
        tick();

        // a few more random keys with random ready
        repeat (3) begin
            start_job({$urandom(), $urandom(), $urandom(), $urandom()});
            drain(1, '0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
